// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encoding and
// bit-timing helpers.
package uart_pkg;

  // Frame-level FSM states, common to both line directions.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_e;

  // Wide enough to count up to 9 data bits.
  localparam int IDX_W = 4;

  // System clock cycles per bit (integer division).
  function automatic int nticks(input int fclk, input int bauds);
    return fclk / bauds;
  endfunction

  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// parameterised reset value so an idle-high line reads as idle after reset.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Capture the asynchronous input through two flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, Wdata data bits LSB first, Wstop stop bits.
// RXD is synchronised, then checked at mid-bit using a down-counter of
// Nticks = Fclk/Bauds system clocks per bit.
// Optional build macro UART_RX_VOTE_EN: each bit decision is a 2-of-3
// majority over three consecutive mid-bit samples, applied one cycle later.
module uart_rx
  import uart_pkg::*;
#(
  // Defaults mirror a 12 MHz / 1 Mbaud 8N1 link; instantiations set all four.
  parameter int Bauds = 1_000_000,
  parameter int Wdata = 8,
  parameter int Wstop = 1,
  parameter int Fclk  = 12_000_000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RXD,
  output logic [Wdata-1:0] DOUT,
  output logic             VLD,
  output logic             FERR
);

  localparam int NTICKS = nticks(Fclk, Bauds);
  localparam int CW     = $clog2(NTICKS);

  localparam logic [CW-1:0]    CNT_RELOAD = CW'(NTICKS - 1);
  localparam logic [CW-1:0]    CNT_HALF   = CW'(NTICKS / 2 - 1);
  localparam logic [CW-1:0]    CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ZERO   = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE    = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] DATA_LAST  = IDX_W'(Wdata - 1);
  localparam logic [IDX_W-1:0] STOP_LAST  = IDX_W'(Wstop - 1);

  logic             rx_s;
  logic             running_s;
  logic             tick_s;
  logic             evt_s;
  logic             bit_s;
  logic             stop_err_s;

  state_e           state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic [Wdata-1:0] shreg_q,  shreg_d;
  logic             err_q,    err_d;
  logic [Wdata-1:0] dout_q,   dout_d;
  logic             vld_q,    vld_d;
  logic             ferr_q,   ferr_d;

  uart_sync #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (RXD),
    .q_o   (rx_s)
  );

  // Counter only runs while a frame is being timed.
  assign running_s = (state_q == START) || (state_q == DATA) || (state_q == STOP);
  assign tick_s    = (cnt_q == CNT_ZERO);

`ifdef UART_RX_VOTE_EN
  logic vote1_q;
  logic vote0_q;
  logic pend_q;

  // Collect the samples around mid-bit; the decision fires the cycle after
  // the counter hits zero, using the live rx as the third vote.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vote1_q <= 1'b1;
      vote0_q <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      pend_q <= running_s && tick_s;
      if (running_s && (cnt_q == CNT_ONE)) begin
        vote1_q <= rx_s;
      end
      if (running_s && tick_s) begin
        vote0_q <= rx_s;
      end
    end
  end

  assign evt_s = pend_q;
  assign bit_s = maj3(vote1_q, vote0_q, rx_s);
`else
  assign evt_s = running_s && tick_s;
  assign bit_s = rx_s;
`endif

  // A stop bit read as 0 now or earlier in this frame.
  assign stop_err_s = err_q | ~bit_s;

  // Next-state logic: bit timing, frame sequencing and output strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    err_d   = err_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;

    if (running_s) begin
      if (tick_s) begin
        cnt_d = CNT_RELOAD;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          // First sample lands half a bit in, i.e. mid start bit.
          cnt_d   = CNT_HALF;
          idx_d   = IDX_ZERO;
          err_d   = 1'b0;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (evt_s) begin
          if (bit_s) begin
            state_d = IDLE;  // too short to be a start bit
          end else begin
            idx_d   = IDX_ZERO;
            state_d = DATA;
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (evt_s) begin
          shreg_d = {bit_s, shreg_q[Wdata-1:1]};
          if (idx_q == DATA_LAST) begin
            idx_d   = IDX_ZERO;
            state_d = STOP;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (evt_s) begin
          if (idx_q == STOP_LAST) begin
            // Leave at mid stop bit so a back-to-back start edge is caught.
            dout_d  = shreg_q;
            vld_d   = ~stop_err_s;
            ferr_d  = stop_err_s;
            idx_d   = IDX_ZERO;
            err_d   = 1'b0;
            state_d = stop_err_s ? BREAK : IDLE;
          end else begin
            err_d   = stop_err_s;
            idx_d   = idx_q + IDX_ONE;
            state_d = STOP;
          end
        end else begin
          state_d = STOP;
        end
      end
      BREAK: begin
        // Line held low after a bad frame: wait for idle, report nothing more.
        if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      idx_q   <= IDX_ZERO;
      shreg_q <= {Wdata{1'b0}};
      err_q   <= 1'b0;
      dout_q  <= {Wdata{1'b0}};
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
    end
  end

  assign DOUT = dout_q;
  assign VLD  = vld_q;
  assign FERR = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 12 MHz / 1 Mbaud, 8 data bits, 1 stop.
// Expected words are queued as frames are driven and compared as strobes appear.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int FCLK  = 12_000_000;
  localparam int BAUDS = 1_000_000;
  localparam int WDATA = 8;
  localparam int WSTOP = 1;
`ifdef UART_RX_VOTE_EN
  localparam int VOTE_LAT = 1;
`else
  localparam int VOTE_LAT = 0;
`endif
  // Pin-to-VLD: 2 sync cycles + Nticks/2 + 9*Nticks + 1 = 117.
  localparam int VLD_LAT = 117 + VOTE_LAT;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RXD = 1'b1;
  logic [7:0] DOUT;
  logic       VLD;
  logic       FERR;

  uart_rx #(
    .Bauds(BAUDS),
    .Wdata(WDATA),
    .Wstop(WSTOP),
    .Fclk (FCLK)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .RXD (RXD),
    .DOUT(DOUT),
    .VLD (VLD),
    .FERR(FERR)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    int         gap;
    logic [7:0] exp_dout;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_vld_cyc = -1;
  bit   relax = 1'b0;
  logic rst_q = 1'b0;
  logic strobe_q = 1'b0;

  always @(posedge CLK) begin
    cyc   <= cyc + 1;
    rst_q <= RST;
  end

  // Output monitor and scoreboard.
  always @(negedge CLK) begin
    if (rst_q) begin
      checks++;
      if (VLD !== 1'b0 || FERR !== 1'b0 || DOUT !== 8'h00 || dut.state_q !== IDLE) begin
        failures++;
        $display("FAIL reset_state: VLD=%b FERR=%b DOUT=%h state=%0d, required 0 0 00 IDLE",
                 VLD, FERR, DOUT, dut.state_q);
      end
    end else begin
      if (VLD === 1'b1 || FERR === 1'b1) begin
        checks++;
        if ((VLD === 1'b1 && FERR === 1'b1) || strobe_q) begin
          failures++;
          $display("FAIL strobe_shape: VLD=%b FERR=%b prev_strobe=%b, required one single-cycle strobe",
                   VLD, FERR, strobe_q);
        end
        if (VLD === 1'b1) last_vld_cyc <= cyc;
        if (relax) begin
          checks++;
          if (VLD === 1'b1 && DOUT === 8'h12) begin
            failures++;
            $display("FAIL reset_frame: VLD with DOUT=%h, required no delivery of interrupted frame", DOUT);
          end
        end else if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: VLD=%b FERR=%b DOUT=%h, required none", VLD, FERR, DOUT);
        end else begin
          mon_e = sb.pop_front();
          checks++;
          if (FERR !== mon_e.ferr || VLD !== ~mon_e.ferr || DOUT !== mon_e.data) begin
            failures++;
            $display("FAIL frame: VLD=%b FERR=%b DOUT=%h, required VLD=%b FERR=%b DOUT=%h",
                     VLD, FERR, DOUT, ~mon_e.ferr, mon_e.ferr, mon_e.data);
          end
        end
      end
    end
    strobe_q <= (VLD === 1'b1) || (FERR === 1'b1);
  end

  task automatic drive_line(input int n, input logic v);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      RXD = v;
      RST = 1'b0;
    end
  endtask

  // One frame, 12 cycles per bit; optional 1-cycle reset or inverted glitch
  // at mid-bit of wire position rst_pos / glitch_pos (0 = start bit).
  task automatic send_frame(input logic [7:0] d, input logic stopv,
                            input int rst_pos, input int glitch_pos,
                            output int t_start);
    logic [9:0] bits;
    logic       v;
    bits = {stopv, d, 1'b0};
    t_start = 0;
    for (int p = 0; p < 10; p++) begin
      for (int o = 0; o < 12; o++) begin
        @(posedge CLK);
        #1;
        if (p == 0 && o == 0) t_start = cyc;
        v = bits[p];
        if (p == glitch_pos && o == 6) v = ~v;
        RXD = v;
        RST = (p == rst_pos && o == 6);
      end
    end
  endtask

  vec_t tbl[6];
  int   t0;

  initial begin
    tbl[0] = '{8'hA5, 24, 8'hA5};
    tbl[1] = '{8'h00,  0, 8'h00};
    tbl[2] = '{8'hFF,  0, 8'hFF};
    tbl[3] = '{8'h55, 24, 8'h55};
    tbl[4] = '{8'h01, 12, 8'h01};
    tbl[5] = '{8'h80, 24, 8'h80};

    RST = 1'b1;
    RXD = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    drive_line(20, 1'b1);

    // Table: basic frames, back-to-back run 00/FF/55, single-bit patterns.
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{data: tbl[i].exp_dout, ferr: 1'b0});
      send_frame(tbl[i].data, 1'b1, -1, -1, t0);
      if (i == 0) begin
        checks++;
        if (last_vld_cyc != t0 + VLD_LAT) begin
          failures++;
          $display("FAIL vld_timing: VLD at cycle %0d, required %0d", last_vld_cyc, t0 + VLD_LAT);
        end
      end
      drive_line(tbl[i].gap, 1'b1);
    end

    // Short low pulse: rejected as a false start.
    drive_line(4, 1'b0);
    drive_line(30, 1'b1);
    checks++;
    if (dut.state_q !== IDLE) begin
      failures++;
      $display("FAIL glitch_idle: state=%0d, required IDLE", dut.state_q);
    end

    // Bad stop bit then line held low: one FERR, then recovery.
    sb.push_back('{data: 8'h3C, ferr: 1'b1});
    send_frame(8'h3C, 1'b0, -1, -1, t0);
    drive_line(50, 1'b0);
    drive_line(24, 1'b1);
    sb.push_back('{data: 8'h81, ferr: 1'b0});
    send_frame(8'h81, 1'b1, -1, -1, t0);
    drive_line(24, 1'b1);

    // Reset during data bit 3: interrupted frame must not deliver 0x12.
    relax = 1'b1;
    send_frame(8'h12, 1'b1, 4, -1, t0);
    drive_line(120, 1'b1);
    relax = 1'b0;
    sb.push_back('{data: 8'h34, ferr: 1'b0});
    send_frame(8'h34, 1'b1, -1, -1, t0);
    drive_line(24, 1'b1);

    // Single-cycle inverted glitch at mid data bit 2 of 0xF0.
`ifdef UART_RX_VOTE_EN
    sb.push_back('{data: 8'hF0, ferr: 1'b0});
`else
    sb.push_back('{data: 8'hF4, ferr: 1'b0});
`endif
    send_frame(8'hF0, 1'b1, -1, 3, t0);
    drive_line(40, 1'b1);

    // Bounded drain of any outstanding expectations.
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge CLK);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected words outstanding, required 0", sb.size());
    end

    // DOUT holds the last word while idle.
    checks++;
`ifdef UART_RX_VOTE_EN
    if (DOUT !== 8'hF0) begin
      failures++;
      $display("FAIL dout_hold: DOUT=%h, required F0", DOUT);
    end
`else
    if (DOUT !== 8'hF4) begin
      failures++;
      $display("FAIL dout_hold: DOUT=%h, required F4", DOUT);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
